// File: rtl/wb_burst_initiator_if.sv
// Wishbone B3 bus between the burst initiator (master) and the external memory port (slave).
interface wb_burst_initiator_if #(
    parameter int unsigned AW = 25
);
    logic [AW-1:0] wb_adr_o;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;
    logic [31:0]   wb_dat_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
endinterface

// File: rtl/wb_burst_initiator.sv
// Wishbone B3 burst initiator: runs 1..MAX_LEN beat linear/wrap read or write bursts per command.
// Define WB_BURST_INITIATOR_RETRY_EN to reissue remaining beats on rty (up to RETRY_LIMIT times).
module wb_burst_initiator #(
    parameter int unsigned AW          = 25,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned RETRY_LIMIT = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [4:0]    cmd_len_i,
    input  logic [1:0]    cmd_bte_i,
    input  logic [31:0]   wdat_i,
    input  logic          wdat_valid_i,
    output logic          wdat_ready_o,
    output logic [31:0]   rdat_o,
    output logic          rdat_valid_o,
    output logic          done_o,
    output logic          err_o,
    wb_burst_initiator_if.master wb
);

    localparam int unsigned LW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_END  = 2'd2,
        S_RTY  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic          r_cyc;
    logic          r_stb;
    logic          r_done;
    logic          r_err;
    logic          r_rdat_valid;
    logic [AW-1:0] r_adr;
    logic [31:0]   r_dat;
    logic [31:0]   r_rdat;
    logic [3:0]    r_sel;
    logic [2:0]    r_cti;
    logic [1:0]    r_bte;
    logic [LW-1:0] r_remaining;
    logic [LW-1:0] r_loads_left;

    logic          w_cmd_accept;
    logic          w_fault;
    logic          w_ack;
    logic          w_last;
    logic          w_wdat_ready;
    logic          w_wdat_take;
    logic          w_rty_retry;
    logic [LW-1:0] w_len;
    logic [AW-1:0] w_adr_next;

    // Wrap bursts increment only the low word-index bits; upper bits stay fixed.
    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] adr, input logic [1:0] bte);
        logic [AW-1:0] mask;
        case (bte)
            2'b01:   mask = AW'(12);
            2'b10:   mask = AW'(28);
            2'b11:   mask = AW'(60);
            default: mask = '1;
        endcase
        return (adr & ~mask) | ((adr + AW'(4)) & mask);
    endfunction

    always_comb begin
        w_len = cmd_len_i;
        if (cmd_len_i == '0) begin
            w_len = LW'(1);
        end else if (32'(cmd_len_i) > MAX_LEN) begin
            w_len = LW'(MAX_LEN);
        end
    end

    assign w_cmd_accept = cmd_valid_i & (r_state == S_IDLE);
    assign w_fault      = r_stb & (wb.wb_err_i | wb.wb_rty_i);
    assign w_ack        = r_stb & wb.wb_ack_i & ~wb.wb_err_i & ~wb.wb_rty_i;
    assign w_last       = (r_remaining == LW'(1));
    assign w_adr_next   = next_adr(r_adr, r_bte);
    assign w_wdat_ready = (r_state == S_BUS) & r_we & (~r_stb | w_ack) &
                          (r_loads_left != '0) & ~w_fault;
    assign w_wdat_take  = w_wdat_ready & wdat_valid_i;

`ifdef WB_BURST_INITIATOR_RETRY_EN
    localparam int unsigned RCW = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

    logic [RCW-1:0] r_retry_cnt;

    assign w_rty_retry = r_stb & wb.wb_rty_i & ~wb.wb_err_i & (32'(r_retry_cnt) < RETRY_LIMIT);

    // Reissue budget, restarted for every command.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_retry_cnt <= '0;
        end else if (w_cmd_accept) begin
            r_retry_cnt <= '0;
        end else if (w_rty_retry) begin
            r_retry_cnt <= r_retry_cnt + RCW'(1);
        end
    end
`else
    assign w_rty_retry = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rdat_valid <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_rdat       <= '0;
            r_sel        <= '0;
            r_cti        <= '0;
            r_bte        <= '0;
            r_remaining  <= '0;
            r_loads_left <= '0;
        end else begin
            r_rdat_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_accept) begin
                        r_state      <= S_BUS;
                        r_cyc        <= 1'b1;
                        r_stb        <= ~cmd_we_i;
                        r_we         <= cmd_we_i;
                        r_adr        <= cmd_adr_i & ~AW'(3);
                        r_bte        <= cmd_bte_i;
                        r_sel        <= 4'hF;
                        r_remaining  <= w_len;
                        r_loads_left <= cmd_we_i ? w_len : LW'(0);
                        r_cti        <= (w_len == LW'(1)) ? 3'b111 : 3'b010;
                    end
                end
                S_BUS: begin
                    if (w_rty_retry) begin
                        r_state <= S_RTY;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                    end else if (w_fault) begin
                        r_state <= S_END;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_sel   <= '0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        if (w_ack) begin
                            if (!r_we) begin
                                r_rdat       <= wb.wb_dat_i;
                                r_rdat_valid <= 1'b1;
                            end
                            if (w_last) begin
                                r_state <= S_END;
                                r_cyc   <= 1'b0;
                                r_stb   <= 1'b0;
                                r_sel   <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_adr       <= w_adr_next;
                                r_remaining <= r_remaining - LW'(1);
                                if (!r_we) begin
                                    r_cti <= (r_remaining == LW'(2)) ? 3'b111 : 3'b010;
                                end
                            end
                        end
                        // Write beats are issued only when a data word is in hand.
                        if (r_we) begin
                            if (w_wdat_take) begin
                                r_dat        <= wdat_i;
                                r_stb        <= 1'b1;
                                r_cti        <= (r_loads_left == LW'(1)) ? 3'b111 : 3'b010;
                                r_loads_left <= r_loads_left - LW'(1);
                            end else if (w_ack) begin
                                r_stb <= 1'b0;
                            end
                        end
                    end
                end
                S_RTY: begin
                    // The rty'd beat is still pending, so strobe it again with the held address/data.
                    r_state <= S_BUS;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                end
                S_END: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = (r_state == S_IDLE);
    assign wdat_ready_o = w_wdat_ready;
    assign rdat_o       = r_rdat;
    assign rdat_valid_o = r_rdat_valid;
    assign done_o       = r_done;
    assign err_o        = r_err;

    assign wb.wb_adr_o  = r_adr;
    assign wb.wb_dat_o  = r_dat;
    assign wb.wb_sel_o  = r_sel;
    assign wb.wb_we_o   = r_we;
    assign wb.wb_cyc_o  = r_cyc;
    assign wb.wb_stb_o  = r_stb;
    assign wb.wb_cti_o  = r_cti;
    assign wb.wb_bte_o  = r_bte;

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Directed bench for wb_burst_initiator: memory slave model with err/rty injection and write-data feeder.
module tb_wb_burst_initiator;

    localparam int unsigned AW = 25;

    typedef struct packed {
        logic [24:0] adr;
        logic [2:0]  cti;
        logic [3:0]  sel;
        logic        we;
        logic [1:0]  bte;
        logic [31:0] dat;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [4:0]    cmd_len;
    logic [1:0]    cmd_bte;
    logic [31:0]   wdat;
    logic          wdat_valid;
    logic          wdat_ready;
    logic [31:0]   rdat;
    logic          rdat_valid;
    logic          done;
    logic          err;

    wb_burst_initiator_if #(.AW(AW)) bus ();

    wb_burst_initiator #(.AW(AW), .MAX_LEN(16), .RETRY_LIMIT(3)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_len_i    (cmd_len),
        .cmd_bte_i    (cmd_bte),
        .wdat_i       (wdat),
        .wdat_valid_i (wdat_valid),
        .wdat_ready_o (wdat_ready),
        .rdat_o       (rdat),
        .rdat_valid_o (rdat_valid),
        .done_o       (done),
        .err_o        (err),
        .wb           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave fault injection, indexed by terminated strobe count since command accept.
    int err_at = 999;
    int rty_at = 999;
    int rty_n  = 0;

    // Write-data source configuration.
    int          n_wdata   = 0;
    int          gap_after = 99;
    int          gap_len   = 0;
    logic [31:0] wdata_arr [16];

    // Monitor/slave state.
    logic [31:0] mem [256];
    int          s_beat;
    logic        s_term;
    logic        s_err_now;
    logic        s_rty_now;
    logic        s_acc;
    logic        s_took;
    beat_t       beats [$];
    logic [31:0] rdq [$];
    int          rv_cnt;
    int          done_cnt;
    logic        last_err;
    int          cyc_gap;
    int          wait_cnt;
    int          ready_bad = 0;
    int          viol = 0;
    logic        busy;
    logic        stb_seen;
    logic        fault_prev;
    logic        cyc_after_fault;

    logic [31:0] t1_adr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [2:0]  cti4   [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
    logic [31:0] t1_rd  [4] = '{32'hA000_0040, 32'hA000_0041, 32'hA000_0042, 32'hA000_0043};
    logic [31:0] t2_adr [8] = '{32'h38, 32'h3C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h30, 32'h34};
    logic [2:0]  t2_cti [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b111};

    always_comb begin
        s_term        = bus.wb_cyc_o & bus.wb_stb_o;
        s_err_now     = (s_beat == err_at);
        s_rty_now     = (s_beat >= rty_at) && (s_beat < rty_at + rty_n);
        bus.wb_err_i  = s_term & s_err_now;
        bus.wb_rty_i  = s_term & s_rty_now & ~s_err_now;
        bus.wb_ack_i  = s_term & ~s_err_now & ~s_rty_now;
        bus.wb_dat_i  = mem[bus.wb_adr_o[9:2]];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            s_beat          <= 0;
            s_acc           <= 1'b0;
            s_took          <= 1'b0;
            rv_cnt          <= 0;
            done_cnt        <= 0;
            last_err        <= 1'b0;
            cyc_gap         <= 0;
            wait_cnt        <= 0;
            busy            <= 1'b0;
            stb_seen        <= 1'b0;
            fault_prev      <= 1'b0;
            cyc_after_fault <= 1'b1;
        end else begin
            s_acc      <= cmd_valid & cmd_ready;
            s_took     <= wdat_valid & wdat_ready;
            fault_prev <= s_term & (bus.wb_err_i | bus.wb_rty_i);
            if (bus.wb_stb_o & ~bus.wb_cyc_o) viol <= viol + 1;
            if (cmd_ready & (bus.wb_cyc_o | done)) ready_bad <= ready_bad + 1;
            if (fault_prev) cyc_after_fault <= bus.wb_cyc_o;
            if (cmd_valid & cmd_ready) begin
                s_beat          <= 0;
                beats.delete();
                rdq.delete();
                rv_cnt          <= 0;
                done_cnt        <= 0;
                last_err        <= 1'b0;
                cyc_gap         <= 0;
                wait_cnt        <= 0;
                busy            <= 1'b1;
                stb_seen        <= 1'b0;
                cyc_after_fault <= 1'b1;
            end else begin
                if (s_term) s_beat <= s_beat + 1;
                if (s_term & bus.wb_ack_i) begin
                    beats.push_back({bus.wb_adr_o, bus.wb_cti_o, bus.wb_sel_o, bus.wb_we_o,
                                     bus.wb_bte_o, bus.wb_dat_o});
                    if (bus.wb_we_o) mem[bus.wb_adr_o[9:2]] <= bus.wb_dat_o;
                end
                if (rdat_valid) begin
                    rdq.push_back(rdat);
                    rv_cnt <= rv_cnt + 1;
                end
                if (done) begin
                    done_cnt <= done_cnt + 1;
                    last_err <= err;
                    busy     <= 1'b0;
                end
                if (bus.wb_stb_o) stb_seen <= 1'b1;
                if (busy & ~bus.wb_cyc_o & ~done) cyc_gap <= cyc_gap + 1;
                if (busy & bus.wb_cyc_o & ~bus.wb_stb_o & stb_seen) wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // Write-data source with an optional valid gap after a given number of accepted words.
    initial begin
        int fed;
        int gap;
        fed        = 0;
        gap        = 0;
        wdat_valid = 1'b0;
        wdat       = '0;
        forever begin
            @(negedge clk);
            if (s_acc) begin
                fed = 0;
                gap = 0;
            end else if (s_took) begin
                fed++;
                if (fed == gap_after) gap = gap_len;
            end else if (gap > 0) begin
                gap--;
            end
            wdat_valid = (fed < n_wdata) && (gap == 0);
            wdat       = (fed < 16) ? wdata_arr[fed[3:0]] : 32'h0;
        end
    end

    task automatic run_cmd(input logic we, input logic [24:0] adr, input logic [4:0] len,
                           input logic [1:0] bte);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        cmd_bte   = bte;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_len   = '0;
        cmd_bte   = '0;
        for (int i = 0; i < 16; i++) wdata_arr[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.wb_stb_o), 32'd0);
        check("rst_wdat_ready", 32'(wdat_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_adr", 32'(bus.wb_adr_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Linear read of 4 beats
        run_cmd(1'b0, 25'h100, 5'd4, 2'b00);
        check("t1_beats", 32'(beats.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_adr%0d", i), 32'(beats[i].adr), t1_adr[i]);
            check($sformatf("t1_cti%0d", i), 32'(beats[i].cti), 32'(cti4[i]));
            check($sformatf("t1_rdat%0d", i), rdq[i], t1_rd[i]);
        end
        check("t1_rv_cnt", 32'(rv_cnt), 32'd4);
        check("t1_err", 32'(last_err), 32'd0);

        // Wrap4 write of 8 beats, data 1..8
        n_wdata = 8;
        for (int i = 0; i < 8; i++) wdata_arr[i] = 32'(i + 1);
        run_cmd(1'b1, 25'h38, 5'd8, 2'b01);
        check("t2_beats", 32'(beats.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_adr%0d", i), 32'(beats[i].adr), t2_adr[i]);
            check($sformatf("t2_cti%0d", i), 32'(beats[i].cti), 32'(t2_cti[i]));
            check($sformatf("t2_sel%0d", i), 32'(beats[i].sel), 32'hF);
            check($sformatf("t2_dat%0d", i), beats[i].dat, 32'(i + 1));
        end
        check("t2_bte", 32'(beats[0].bte), 32'd1);
        check("t2_mem_30", mem[8'h0C], 32'd7);
        check("t2_mem_34", mem[8'h0D], 32'd8);
        check("t2_mem_38", mem[8'h0E], 32'd5);
        check("t2_mem_3c", mem[8'h0F], 32'd6);
        check("t2_wait", 32'(wait_cnt), 32'd0);
        check("t2_err", 32'(last_err), 32'd0);

        // Write with a 3-cycle data gap after the second word
        n_wdata   = 4;
        gap_after = 2;
        gap_len   = 3;
        wdata_arr[0] = 32'h1111_0000;
        wdata_arr[1] = 32'h2222_0000;
        wdata_arr[2] = 32'h3333_0000;
        wdata_arr[3] = 32'h4444_0000;
        run_cmd(1'b1, 25'h80, 5'd4, 2'b00);
        check("t3_beats", 32'(beats.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_cti%0d", i), 32'(beats[i].cti), 32'(cti4[i]));
        end
        check("t3_wait", 32'(wait_cnt), 32'd3);
        check("t3_cyc_gap", 32'(cyc_gap), 32'd0);
        check("t3_mem_80", mem[8'h20], 32'h1111_0000);
        check("t3_mem_84", mem[8'h21], 32'h2222_0000);
        check("t3_mem_88", mem[8'h22], 32'h3333_0000);
        check("t3_mem_8c", mem[8'h23], 32'h4444_0000);
        n_wdata   = 0;
        gap_after = 99;
        gap_len   = 0;

        // Read of 16 with err on the 5th strobe
        err_at = 4;
        run_cmd(1'b0, 25'h300, 5'd16, 2'b00);
        check("t4_beats", 32'(beats.size()), 32'd4);
        check("t4_rv_cnt", 32'(rv_cnt), 32'd4);
        check("t4_rdat3", rdq[3], 32'hA000_00C3);
        check("t4_err", 32'(last_err), 32'd1);
        check("t4_cyc_drop", 32'(cyc_after_fault), 32'd0);
        err_at = 999;

        // Single-beat read with len=0
        run_cmd(1'b0, 25'h10C, 5'd0, 2'b00);
        check("t5_beats", 32'(beats.size()), 32'd1);
        check("t5_adr", 32'(beats[0].adr), 32'h10C);
        check("t5_cti", 32'(beats[0].cti), 32'b111);
        check("t5_rv_cnt", 32'(rv_cnt), 32'd1);
        check("t5_rdat", rdq[0], 32'hA000_0043);
        check("t5_err", 32'(last_err), 32'd0);
        check("t5_ready_after", 32'(cmd_ready), 32'd1);

`ifdef WB_BURST_INITIATOR_RETRY_EN
        // Single rty on the 3rd beat is retried from the current address
        rty_at = 2;
        rty_n  = 1;
        run_cmd(1'b0, 25'h200, 5'd6, 2'b00);
        check("t6_beats", 32'(beats.size()), 32'd6);
        check("t6_adr2", 32'(beats[2].adr), 32'h208);
        check("t6_adr5", 32'(beats[5].adr), 32'h214);
        check("t6_cti5", 32'(beats[5].cti), 32'b111);
        check("t6_rv_cnt", 32'(rv_cnt), 32'd6);
        check("t6_rdat5", rdq[5], 32'hA000_0085);
        check("t6_cyc_gap", 32'(cyc_gap), 32'd1);
        check("t6_err", 32'(last_err), 32'd0);

        // Four consecutive rty exhaust the retry budget
        rty_at = 1;
        rty_n  = 4;
        run_cmd(1'b0, 25'h200, 5'd6, 2'b00);
        check("t6b_rv_cnt", 32'(rv_cnt), 32'd1);
        check("t6b_cyc_gap", 32'(cyc_gap), 32'd3);
        check("t6b_err", 32'(last_err), 32'd1);
        rty_at = 999;
        rty_n  = 0;
`else
        // Without retry support, rty ends the command like err
        rty_at = 2;
        rty_n  = 1;
        run_cmd(1'b0, 25'h100, 5'd4, 2'b00);
        check("t6_rty_beats", 32'(beats.size()), 32'd2);
        check("t6_rty_rv_cnt", 32'(rv_cnt), 32'd2);
        check("t6_rty_cyc_gap", 32'(cyc_gap), 32'd0);
        check("t6_rty_err", 32'(last_err), 32'd1);
        rty_at = 999;
        rty_n  = 0;
`endif

        check("stb_without_cyc", 32'(viol), 32'd0);
        check("ready_while_busy", 32'(ready_bad), 32'd0);

        // Asynchronous reset in the middle of a burst
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 25'h100;
        cmd_len   = 5'd16;
        cmd_bte   = 2'b00;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_cyc_before", 32'(bus.wb_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_cyc_async", 32'(bus.wb_cyc_o), 32'd0);
        check("t7_stb_async", 32'(bus.wb_stb_o), 32'd0);
        check("t7_ready_async", 32'(cmd_ready), 32'd1);
        check("t7_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_idle_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("t7_no_done", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_initiator.md
Name: wb_burst_initiator

Overview:
Wishbone B3 burst initiator that drives the external memory bus from a simple command interface. Each command is a read or write of 1-16 words using incrementing or wrapping bursts. It is the initiator end of the external memory slave port and serves as the DMA/test-traffic engine for the 32MB external RAM. A write-data stream feeds it, and a read-data stream carries results out.

Parameters:
AW, 25, byte address width (log2 of 32MB)
MAX_LEN, 16, maximum beats per command (power of two, ≤16)
RETRY_LIMIT, 3, maximum reissues per command (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  AW  start byte address; bits[1:0] ignored
cmd_len_i  in  5  beat count 1..MAX_LEN; 0 is treated as 1
cmd_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wdat_i  in  32  write data
wdat_valid_i  in  1  write data valid
wdat_ready_o  out  1  write data consumed when valid&ready
rdat_o  out  32  read data
rdat_valid_o  out  1  one-cycle strobe per read beat; no backpressure
done_o  out  1  one-cycle pulse when a command ends
err_o  out  1  qualified by done_o: command ended on err (or rty)
wb_adr_o  out  AW  byte address, bits[1:0]=0
wb_dat_o  out  32  write data
wb_sel_o  out  4  always 4'hF while stb_o is high
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type
wb_bte_o  out  2  burst type
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error
wb_rty_i  in  1  retry
wb_dat_i  in  32  read data

Behaviour:
- Reset (async, wb_rst_n_i low): state=IDLE. cyc/stb/we/done/err/rdat_valid=0. adr, dat_o, sel, cti, bte, rdat=0. cmd_ready_o=(state==IDLE), so it is 1 during reset. wdat_ready_o=0.
- States: IDLE -> BUS -> END -> IDLE.
- IDLE: on cmd accept, latch we/adr/bte and remaining=len. Assert cyc_o next cycle. wb_bte_o=cmd_bte.
- BUS read:
  - stb_o is high continuously.
  - cti=3'b010 while remaining>1; 3'b111 on the final beat. A single-beat command uses 3'b111 from the start.
  - On each ack: rdat_o<=dat_i, rdat_valid_o=1 the next cycle, advance adr, remaining-=1.
- BUS write:
  - wdat_ready_o = state==BUS & we & (!stb_o | ack_i) & loads_left!=0.
  - On accept: dat_o<=wdat_i, stb_o<=1, cti per the same last-beat rule (computed on loads_left).
  - On ack with no new accept: stb_o<=0. This is a master wait state; cyc stays high.
- Address advance: +4 for linear. For wrap N, bits[log2(4N)-1:2] increment modulo N and the upper bits are held.
- Final ack: drop cyc/stb next cycle, go to END.
- END: done_o=1 for one cycle, err_o valid in the same cycle, then IDLE. Back-to-back commands therefore have ≥1 idle bus cycle.
- err_i (while stb): abort immediately. Drop cyc/stb, go to END with err_o=1. Beats already acked stand, and no further wdat is consumed.
- rty_i without the feature: same as err_i.
- Simultaneous ack and err: err wins and the beat is not counted.
- Reset mid-burst: cyc drops asynchronously and the command is lost; no done_o is generated.
- stb_o never asserts without cyc_o. adr/we/cti/sel are stable while stb_o is high and ack_i is low.

Optional Feature:
Macro WB_BURST_INITIATOR_RETRY_EN.
- Enabled: on rty_i, drop cyc/stb for exactly one cycle, then reissue the remaining beats from the current address with the same bte.
  - Write beat data held in dat_o is reused, not re-fetched.
  - Reissues beyond RETRY_LIMIT end the command with err_o=1.
- Disabled: rty_i is treated as err_i, and no retry counter is synthesized.

Test Plan:
1. Read len=4, adr=0x100, bte=00, slave acks every cycle -> adr 0x100/104/108/10C; cti 010,010,010,111; 4 rdat_valid strobes; one done_o with err_o=0.
2. Write len=8, adr=0x38, bte=01 (wrap4), data 1..8 -> adr 0x38,0x3C,0x30,0x34,0x38,...; memory holds the last-written values; sel=F on every beat; cti=111 only on the 8th beat.
3. Write len=4 with a 3-cycle wdat_valid gap after beat 2 -> stb_o low during the gap, cyc_o held, cti stays 010, all 4 words written correctly.
4. Read len=16, err_i on beat 5 -> cyc drops the next cycle, exactly 4 rdat_valid strobes, done_o with err_o=1.
5. Single-beat read, len=0 -> treated as 1, cti=111, 1 rdat_valid; cmd_ready_o low during BUS/END and high again afterwards.
6. RETRY_EN: rty_i on beat 3 of a len=6 read at 0x200 -> 1 idle cycle, reissue at 0x208 for 4 beats, 6 total rdat_valid, err_o=0. With 4 consecutive rty -> err_o=1.
